// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access occupies the memory for one ACCESS cycle; reads add a RESP cycle.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state_q, state_d;
    logic   winner;
    logic   last_winner;
    logic   we_lat;
    logic   pick_1;
    logic   any_req;

    assign any_req = req_0 | req_1;

    // On a tie the requester that did not win last time goes first.
    assign pick_1 = (req_0 && req_1) ? ~last_winner : req_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = we_lat ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner      <= 1'b0;
            last_winner <= 1'b1;
            we_lat      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_0     <= '0;
            rdata_1     <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                winner      <= pick_1;
                last_winner <= pick_1;
                we_lat      <= pick_1 ? we_1    : we_0;
                mem_addr    <= pick_1 ? addr_1  : addr_0;
                mem_wdata   <= pick_1 ? wdata_1 : wdata_0;
            end
            // Read data is captured at the edge that ends ACCESS.
            if (state_q == ACCESS && !we_lat) begin
                if (winner) begin
                    rdata_1 <= mem_rdata;
                end else begin
                    rdata_0 <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        gnt_0     = 1'b0;
        gnt_1     = 1'b0;
        rvalid_0  = 1'b0;
        rvalid_1  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                gnt_0     = ~winner;
                gnt_1     = winner;
                mem_read  = ~we_lat;
                mem_write = we_lat;
            end
            RESP: begin
                rvalid_0 = ~winner;
                rvalid_1 = winner;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_0, we_0, req_1, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // The memory the arbiter drives: combinational read, write on rising edge.
    logic [DW-1:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the current transaction
    // (0 = free, 1 = grant cycle, 2 = response cycle) and its length.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rdata [2];
    int            mpos, mlen;
    bit            mwin, mlast, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    int            order [$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mpos = 0; mlen = 0; mwin = 1'b0; mlast = 1'b1; mwe = 1'b0;
        maddr = '0; mwdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    task automatic modelEdge();
        if (mpos == 1) begin
            if (mwe) ref_mem[maddr] = mwdata;
            else     exp_rdata[mwin] = ref_mem[maddr];
        end
        if (mpos != 0) begin
            mpos = (mpos == mlen) ? 0 : mpos + 1;
        end else if (req_0 || req_1) begin
            if (req_0 && req_1) mwin = ~mlast;
            else                mwin = req_1;
            mlast  = mwin;
            mwe    = mwin ? we_1 : we_0;
            maddr  = mwin ? addr_1 : addr_0;
            mwdata = mwin ? wdata_1 : wdata_0;
            mlen   = mwe ? 1 : 2;
            mpos   = 1;
        end
    endtask

    task automatic checkAll();
        bit acc, rsp;
        acc = (mpos == 1);
        rsp = (mpos == 2);
        checkOutput("busy",      busy,      mpos != 0);
        checkOutput("gnt_0",     gnt_0,     acc && !mwin);
        checkOutput("gnt_1",     gnt_1,     acc && mwin);
        checkOutput("rvalid_0",  rvalid_0,  rsp && !mwin);
        checkOutput("rvalid_1",  rvalid_1,  rsp && mwin);
        checkOutput("mem_read",  mem_read,  acc && !mwe);
        checkOutput("mem_write", mem_write, acc && mwe);
        checkOutput("mem_addr",  mem_addr,  maddr);
        checkOutput("mem_wdata", mem_wdata, mwdata);
        checkOutput("rdata_0",   rdata_0,   exp_rdata[0]);
        checkOutput("rdata_1",   rdata_1,   exp_rdata[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic applyStimulus(input int p, input bit r, input bit w,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d;
        end else begin
            req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d;
        end
    endtask

    task automatic newTxn(input int p);
        applyStimulus(p, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
    endtask

    // Reset pulse from a negedge: outputs must clear without waiting for a clock.
    task automatic midReset();
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[2] = 32'd25; ref_mem[2] = 32'd25;
        mem[3] = '0;     ref_mem[3] = '0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();

        $display("[TB] single read of word 2");
        applyStimulus(0, 1'b1, 1'b0, 6'd2, '0);
        tick();
        checkOutput("rd_gnt0", gnt_0, 1);
        checkOutput("rd_mem_read", mem_read, 1);
        checkOutput("rd_addr", mem_addr, 2);
        applyStimulus(0, 1'b0, 1'b0, 6'd2, '0);
        tick();
        checkOutput("rd_rvalid0", rvalid_0, 1);
        checkOutput("rd_rdata0", rdata_0, 25);
        tick();
        checkOutput("rd_busy_done", busy, 0);

        $display("[TB] port 1 write then port 0 read");
        applyStimulus(1, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        tick();
        checkOutput("wr_gnt1", gnt_1, 1);
        checkOutput("wr_mem_write", mem_write, 1);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("wr_busy_done", busy, 0);
        applyStimulus(0, 1'b1, 1'b0, 6'd5, '0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("wr_rd_rdata0", rdata_0, 32'hDEADBEEF);
        checkOutput("wr_rd_rdata1", rdata_1, 0);
        tick();

        $display("[TB] reset abort during write ACCESS");
        applyStimulus(0, 1'b1, 1'b1, 6'd3, 32'h12345678);
        tick();
        checkOutput("abort_pre_write", mem_write, 1);
        midReset();
        checkOutput("abort_mem_write", mem_write, 0);
        checkOutput("abort_busy", busy, 0);

        $display("[TB] contention after reset");
        applyStimulus(0, 1'b1, 1'b0, 6'd1, '0);
        applyStimulus(1, 1'b1, 1'b0, 6'd4, '0);
        for (int c = 0; c < 30 && order.size() < 4; c++) begin
            tick();
            if (gnt_0) order.push_back(0);
            if (gnt_1) order.push_back(1);
        end
        checkOutput("cont_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) checkOutput("cont_order", order[i], i % 2);
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (3) tick();

        $display("[TB] read back aborted address");
        applyStimulus(0, 1'b1, 1'b0, 6'd3, '0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("abort_readback", rdata_0, 0);
        tick();

        $display("[TB] request raised during RESP");
        applyStimulus(0, 1'b1, 1'b0, 6'd2, '0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1, 1'b1, 1'b0, 6'd7, '0);
        tick();
        checkOutput("ign_gnt1_idle", gnt_1, 0);
        tick();
        checkOutput("ign_gnt1_access", gnt_1, 1);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            tick();
            if (c % 97 == 96) begin
                midReset();
            end else begin
                if (req_0 && mpos == 1 && !mwin) begin
                    if ($urandom_range(1) == 1) newTxn(0);
                    else applyStimulus(0, 1'b0, 1'b0, '0, '0);
                end else if (!req_0 && $urandom_range(3) == 0) begin
                    newTxn(0);
                end
                if (req_1 && mpos == 1 && mwin) begin
                    if ($urandom_range(1) == 1) newTxn(1);
                    else applyStimulus(1, 1'b0, 1'b0, '0, '0);
                end else if (!req_1 && $urandom_range(3) == 0) begin
                    newTxn(1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning data-memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data-memory word width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have, per requester k in {0,1}, port req_k  input  1  access request.
REQ-006 The block SHALL have, per k, port we_k  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have, per k, port addr_k  input  ADDR_W  word address.
REQ-008 The block SHALL have, per k, port wdata_k  input  DATA_W  write data.
REQ-009 The block SHALL have, per k, port gnt_k  output  1  one-cycle grant pulse.
REQ-010 The block SHALL have, per k, port rvalid_k  output  1  one-cycle read-data-valid pulse.
REQ-011 The block SHALL have, per k, port rdata_k  output  DATA_W  registered read data.
REQ-012 The block SHALL have port mem_read  output  1  memory read enable.
REQ-013 The block SHALL have port mem_write  output  1  memory write enable.
REQ-014 The block SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-015 The block SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-016 The block SHALL have port mem_rdata  input  DATA_W  memory combinational read data.
REQ-017 The block SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-019 IDLE, no req: SHALL stay IDLE.
REQ-020 IDLE, any req at edge N: SHALL latch winner, we, addr, wdata and enter ACCESS at N+1.
REQ-021 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester other than last_winner wins; last_winner updates on each grant.
REQ-022 gnt_k SHALL be high exactly during the ACCESS cycle of requester k's transaction.
REQ-023 In ACCESS, mem_addr and mem_wdata SHALL equal the latched values; mem_read = !we_lat and mem_write = we_lat, both derived combinationally from state.
REQ-024 mem_read and mem_write SHALL be 0 in IDLE and RESP; never both high.
REQ-025 Write: memory updates at the edge ending ACCESS; ACCESS SHALL then go to IDLE (2-cycle occupancy).
REQ-026 Read: mem_rdata SHALL be captured into rdata_k at the edge ending ACCESS; ACCESS SHALL then go to RESP.
REQ-027 In RESP, rvalid_k SHALL be high for the read's owner only; RESP SHALL always go to IDLE (3-cycle occupancy).
REQ-028 rdata_k SHALL hold its value until the next read response to port k; the other port's rdata SHALL be unaffected.
REQ-029 Requesters SHALL keep req, we, addr, wdata stable until gnt; a req still high at the next IDLE edge SHALL be treated as a new request.
REQ-030 Requests arriving in ACCESS/RESP SHALL be ignored until IDLE; no request SHALL be lost if held.
REQ-031 mem_addr and mem_wdata SHALL hold their last latched values outside ACCESS.

Reset
REQ-032 rst high SHALL immediately force state IDLE, gnt_k=0, rvalid_k=0, rdata_k=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0, last_winner=1.
REQ-033 Reset asserted during ACCESS SHALL abort the transaction: no memory write occurs, no rvalid issued.
REQ-034 After rst deasserts, first edge with req SHALL behave as REQ-020; requester 0 wins a tie.

Verification
REQ-035 Reset: rst=1 mid-stream -> all outputs 0 same cycle; after release, busy=0.
REQ-036 Single read: memory word 2 = 25, req_0=1, we_0=0, addr_0=2 at edge N -> gnt_0, mem_read=1, mem_addr=2 at N+1; rvalid_0=1, rdata_0=25 at N+2; busy=0 at N+3.
REQ-037 Write then read: port 1 writes 0xDEADBEEF to addr 5 -> gnt_1, mem_write=1 one cycle; port 0 then reads addr 5 -> rdata_0=0xDEADBEEF, rdata_1 unchanged.
REQ-038 Contention: req_0 and req_1 both held after reset -> grant order 0,1,0,1; each port sees its own rvalid only.
REQ-039 Reset abort: rst asserted during ACCESS of port 0 write of 0x12345678 to addr 3 (prior value 0) -> mem_write drops same cycle; later read of addr 3 returns 0.
REQ-040 Ignored request: req_1 raised during port 0 RESP -> no gnt_1 until IDLE, then gnt_1 at next ACCESS.
